// File: rtl/bit_serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: requester drives operands
// and start, the adder returns status and the registered result.
interface bit_serial_adder_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell with a registered carry consumes the
// operands LSB first, one sum bit per clock, result latched on the last bit.
module bsa_full_adder (
    input  logic x_i,
    input  logic y_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = x_i ^ y_i ^ ci_i;
    assign co_o = (x_i & y_i) | (ci_i & (x_i ^ y_i));
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    bit_serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, s_sr_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q, busy_q, done_q;

    logic             fa_s, fa_co, last_bit;
    logic [WIDTH-1:0] s_sr_d;

    bsa_full_adder u_fa (
        .x_i  (a_sr_q[0]),
        .y_i  (b_sr_q[0]),
        .ci_i (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    // Shift form rather than a slice so WIDTH=1 elaborates cleanly.
    assign s_sr_d   = (s_sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sr_q  <= bus.a;
                        b_sr_q  <= bus.b;
                        carry_q <= bus.cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ADD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ADD: begin
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    s_sr_q  <= s_sr_d;
                    carry_q <= fa_co;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_bit) begin
                        sum_q   <= s_sr_d;
                        cout_q  <= fa_co;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder: directed and random checks at WIDTH=8, random
// regressions at WIDTH=1 and WIDTH=32, results scored from a queue at done.
module tb_bit_serial_adder;
    logic clk = 1'b0;
    logic rst8, rstx;
    int   errs = 0;
    int   nchk = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- WIDTH=8 instance ----------------
    bit_serial_adder_if #(8) if8 ();
    bit_serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(if8));

    logic [8:0] q8[$];
    int  cyc = 0, done_cnt8 = 0, last_done = 0;
    bit  b2b = 0, b2b_seen = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst8 && if8.done) begin
            done_cnt8++;
            chk("db8", if8.busy, 0);
            chk("q8_nonempty", q8.size() > 0, 1);
            if (q8.size() > 0) chk("sum8", {if8.cout, if8.sum}, q8.pop_front());
            if (b2b) begin
                if (b2b_seen) chk("b2b_gap", cyc - last_done, 9);
                b2b_seen = 1;
            end
            last_done = cyc;
        end
    end

    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit lat);
        int to;
        logic [8:0] e;
        to = 0;
        @(negedge clk);
        while (if8.busy && to < 100) begin @(negedge clk); to++; end
        if (to >= 100) chk("busy8_to", if8.busy, 0);
        if8.a = a; if8.b = b; if8.cin = c; if8.start = 1'b1;
        e = a + b + c;
        q8.push_back(e);
        @(posedge clk); #1 if8.start = 1'b0;
        if (lat) begin
            for (int i = 1; i < 8; i++) begin
                @(posedge clk); #1 chk("lat_early", if8.done, 0);
            end
            @(posedge clk); #1 chk("lat", if8.done, 1);
        end
    endtask

    // ---------------- WIDTH=1 and WIDTH=32 random ----------------
    for (genvar g = 0; g < 2; g++) begin : g_rnd
        localparam int W = (g == 0) ? 1 : 32;
        bit_serial_adder_if #(W) ifx ();
        bit_serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rstx), .bus(ifx));
        logic [W:0] q[$];
        logic [W:0] e;
        bit fin = 0;
        int to;

        always @(negedge clk) begin
            if (!rstx && ifx.done) begin
                chk($sformatf("db%0d", W), ifx.busy, 0);
                chk($sformatf("q%0d_nonempty", W), q.size() > 0, 1);
                if (q.size() > 0) chk($sformatf("sum%0d", W), {ifx.cout, ifx.sum}, q.pop_front());
            end
        end

        initial begin
            ifx.start = 1'b0; ifx.a = '0; ifx.b = '0; ifx.cin = 1'b0;
            @(negedge clk);
            while (rstx) @(negedge clk);
            for (int i = 0; i < 1000; i++) begin
                to = 0;
                while (ifx.busy && to < 100) begin @(negedge clk); to++; end
                if (to >= 100) chk($sformatf("busy%0d_to", W), ifx.busy, 0);
                ifx.a = W'($urandom); ifx.b = W'($urandom); ifx.cin = 1'($urandom);
                e = ifx.a + ifx.b + ifx.cin;
                q.push_back(e);
                ifx.start = 1'b1;
                @(negedge clk); ifx.start = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            repeat (W + 4) @(negedge clk);
            chk($sformatf("drain%0d", W), q.size(), 0);
            fin = 1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int d0, to;
        logic [8:0] e;
        rst8 = 1'b1; rstx = 1'b1;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sum", if8.sum, 0);
        chk("rst_cout", if8.cout, 0);
        chk("rst_busy", if8.busy, 0);
        chk("rst_done", if8.done, 0);
        @(negedge clk); rst8 = 1'b0; rstx = 1'b0;
        d0 = done_cnt8;
        repeat (20) @(negedge clk);
        chk("idle_done", done_cnt8 - d0, 0);
        chk("idle_busy", if8.busy, 0);

        go8(8'h00, 8'h00, 1'b0, 1);
        go8(8'h7F, 8'h01, 1'b0, 1);
        go8(8'hFF, 8'h01, 1'b0, 1);
        go8(8'hA5, 8'h5A, 1'b1, 1);
        go8(8'hFF, 8'hFF, 1'b1, 1);
        repeat (3) @(negedge clk);

        // start pulsed mid-operation must be ignored; old result held
        d0 = done_cnt8;
        go8(8'h03, 8'h04, 1'b0, 0);
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF;
        chk("hold_busy", if8.busy, 1);
        chk("hold_sum", {if8.cout, if8.sum}, 9'h1FF);
        @(negedge clk);
        if8.start = 1'b0; if8.a = 8'h11; if8.b = 8'h22;
        chk("hold_sum2", {if8.cout, if8.sum}, 9'h1FF);
        repeat (12) @(negedge clk);
        chk("one_done", done_cnt8 - d0, 1);
        chk("ign_sum", {if8.cout, if8.sum}, 9'h007);

        // reset in ADD cycle 4 aborts with no done
        go8(8'h12, 8'h34, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1 rst8 = 1'b1;
        #1;
        chk("abort_sum", if8.sum, 0);
        chk("abort_cout", if8.cout, 0);
        chk("abort_busy", if8.busy, 0);
        chk("abort_done", if8.done, 0);
        q8.delete();
        d0 = done_cnt8;
        @(negedge clk); @(negedge clk); rst8 = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_no_done", done_cnt8 - d0, 0);
        go8(8'h40, 8'h41, 1'b1, 1);
        repeat (3) @(negedge clk);

        // start held high: one result every 9 cycles
        b2b = 1;
        for (int r = 0; r < 4; r++) begin
            if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom);
            if8.start = 1'b1;
            e = if8.a + if8.b + if8.cin;
            q8.push_back(e);
            repeat (8) begin
                @(negedge clk);
                if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom);
            end
            @(negedge clk);
        end
        if8.start = 1'b0;
        d0 = done_cnt8;
        repeat (12) @(negedge clk);
        b2b = 0;
        chk("b2b_last", done_cnt8 - d0, 1);
        chk("b2b_drain", q8.size(), 0);

        for (int i = 0; i < 1000; i++) begin
            go8(8'($urandom), 8'($urandom), 1'($urandom), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        chk("rnd8_drain", q8.size(), 0);

        to = 0;
        while (!(g_rnd[0].fin && g_rnd[1].fin) && to < 60000) begin @(negedge clk); to++; end
        chk("rnd_fin", {g_rnd[0].fin, g_rnd[1].fin}, 2'b11);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Bit-serial adder that adds two WIDTH-bit operands plus a carry-in, LSB first, through a single full-adder cell with a registered carry. It computes one sum bit per clock. It sits directly upstream of our full-adder cell: it sequences the x/y/cin bits into the cell and collects the sum and carry-out bits. It trades latency for area in datapaths where a ripple adder is too large.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1..32
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when the block can accept it
- a  input  WIDTH  operand A; captured on an accepted start
- b  input  WIDTH  operand B; captured on an accepted start
- cin  input  1  carry-in; captured on an accepted start
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse when sum/cout become valid
- sum  output  WIDTH  registered result, low WIDTH bits of a+b+cin
- cout  output  1  registered carry-out, bit WIDTH of a+b+cin

## Operation
- Internal state: a_sr, b_sr, s_sr (WIDTH each), carry (1), bit counter cnt (ceil(log2(WIDTH+1)) bits), FSM state.
- FSM has three states: IDLE, ADD and DONE.
- IDLE:
  - busy=0, done=0.
  - On start=1: load a_sr=a, b_sr=b, carry=cin, cnt=0, then go to ADD.
- ADD:
  - busy=1.
  - Each cycle, the full-adder cell takes x=a_sr[0], y=b_sr[0], cin=carry.
  - Its sum bit is shifted into s_sr at the MSB (s_sr <= {bit, s_sr[WIDTH-1:1]}).
  - a_sr and b_sr shift right by one; carry takes the cell's cout; cnt increments.
  - When cnt==WIDTH-1 in this cycle (the last bit), go to DONE.
  - The output registers then capture sum <= final s_sr and cout <= final carry.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - A start=1 in DONE is accepted exactly as in IDLE: reload and go to ADD.
  - Otherwise go to IDLE.
- start is ignored while in ADD. Operands may change freely after capture.
- sum and cout hold their value from completion until the next completion. They never show partial results.
- Arithmetic: {cout,sum} == a + b + cin, computed at WIDTH+1 bits, with no overflow flag.
- WIDTH=1: ADD lasts exactly one cycle.

## Timing
- Reset (async assert, clk-synchronous release):
  - FSM=IDLE; busy=0, done=0, sum=0, cout=0.
  - All internal registers are 0.
- Reset asserted mid-operation aborts the addition. Outputs return to reset values immediately, and no done pulse is issued.
- Latency:
  - start is accepted at edge k.
  - busy is high for cycles k+1 .. k+WIDTH.
  - done, sum and cout are updated at edge k+WIDTH and visible during cycle k+WIDTH..k+WIDTH+1.
- Throughput: back-to-back starts (start held high, or asserted in DONE) give one result every WIDTH+1 cycles.
- done and busy are never high in the same cycle.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset, then check outputs while idle:
  - sum=0, cout=0, busy=0, done=0.
  - Holding start=0 for 20 cycles produces no done.
- WIDTH=8 basic sums:
  - a=8'h00, b=8'h00, cin=0 -> sum=8'h00, cout=0.
  - a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0.
  - In both cases done rises exactly 8 edges after the accepting edge.
- Carry propagation:
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
  - a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1.
  - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Ignored start and changing operands:
  - Start a=8'h03, b=8'h04, cin=0.
  - During busy, pulse start with a=8'hFF, b=8'hFF and change the a/b inputs.
  - Result must be sum=8'h07, cout=0, with a single done pulse.
  - The previous sum is held while busy.
- Reset mid-operation and back-to-back operation:
  - Assert rst at ADD cycle 4 -> outputs 0 immediately and no done. After release, an idle block accepts a new start.
  - Hold start=1 with changing operands -> done every 9 cycles, each result matching the operands present at its accepting edge.
- Random regression:
  - 1000 random a, b, cin with random start gaps, at WIDTH=1, 8 and 32.
  - Checker compares {cout,sum} against a+b+cin at each done pulse, and asserts that done and busy are never both high.
